// File: rtl/z80_snoop_pkg.sv
// Shared types and default constants for the Z80 framebuffer write snooper.
// The strobe vector is packed {MREQ_n, IORQ_n, WR_n, RFSH_n}.
package z80_snoop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_WAIT
    } refresh_state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } fb_wr_t;

    localparam logic [15:0] DEF_WIN_BASE        = 16'hE000;
    localparam int          DEF_WIN_SIZE_LOG2   = 10;
    localparam int          DEF_FIFO_DEPTH_LOG2 = 3;
    localparam int          DEF_HOLDOFF_CYCLES  = 50000;

    localparam int STB_MREQ = 3;
    localparam int STB_IORQ = 2;
    localparam int STB_WR   = 1;
    localparam int STB_RFSH = 0;

    localparam logic [3:0] STB_IDLE      = 4'b1111;
    // MREQ_n=0, IORQ_n=1, WR_n=0, RFSH_n=1
    localparam logic [3:0] STB_MEM_WRITE = 4'b0101;

endpackage

// File: rtl/snoop_fifo.sv
// Small show-ahead synchronous FIFO; a push into a full FIFO is accepted
// when a pop happens on the same edge.
module snoop_fifo #(
    parameter int WIDTH = 24,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             accept_o
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             empty;
    logic             full;
    logic             pop_ok;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok   = pop_i && !empty;
    assign accept_o = push_i && (!full || pop_ok);
    assign valid_o  = !empty;
    assign data_o   = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (accept_o) begin
            mem[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (accept_o) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/z80_write_snoop.sv
// Passive Z80 bus monitor: queues CPU writes into the framebuffer window and
// requests an OLED refresh once write activity has settled.
module z80_write_snoop
    import z80_snoop_pkg::*;
#(
    parameter logic [15:0] WIN_BASE        = DEF_WIN_BASE,
    parameter int          WIN_SIZE_LOG2   = DEF_WIN_SIZE_LOG2,
    parameter int          FIFO_DEPTH_LOG2 = DEF_FIFO_DEPTH_LOG2,
    parameter int          HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MREQ_n,
    input  logic                     IORQ_n,
    input  logic                     WR_n,
    input  logic                     RFSH_n,
    input  logic [15:0]              A,
    input  logic [7:0]               D,
    output logic                     fb_wr_valid,
    input  logic                     fb_wr_ready,
    output logic [WIN_SIZE_LOG2-1:0] fb_wr_addr,
    output logic [7:0]               fb_wr_data,
    input  logic                     busy,
    output logic                     refresh,
    output logic                     overflow
);
    localparam int              CW        = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLDOFF_CYCLES);
    localparam int              TAG_W     = 16 - WIN_SIZE_LOG2;

    logic [3:0]     stb_s1_q;
    logic [3:0]     stb_s2_q;
    logic           wr_cyc_prev_q;
    logic [1:0]     live_q;
    logic           arm_q;
    logic           arm_d;
    logic [15:0]    a_q;
    logic [7:0]     d_q;
    logic           overflow_q;
    refresh_state_e state_q;
    refresh_state_e state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;

    logic   wr_cyc;
    logic   take;
    logic   in_win;
    logic   push_req;
    logic   push_ok;
    fb_wr_t push_entry;
    fb_wr_t head;
    logic   unused_head_tag;

    always_ff @(posedge clk) begin
        a_q <= A;
        d_q <= D;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stb_s1_q      <= STB_IDLE;
            stb_s2_q      <= STB_IDLE;
            wr_cyc_prev_q <= 1'b0;
            live_q        <= 2'b00;
            arm_q         <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            stb_s1_q      <= {MREQ_n, IORQ_n, WR_n, RFSH_n};
            stb_s2_q      <= stb_s1_q;
            wr_cyc_prev_q <= wr_cyc;
            live_q        <= {live_q[0], 1'b1};
            arm_q         <= arm_d;
            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign wr_cyc   = (stb_s2_q == STB_MEM_WRITE);
    assign take     = wr_cyc && wr_cyc_prev_q && arm_q;
    assign in_win   = (a_q[15:WIN_SIZE_LOG2] == WIN_BASE[15:WIN_SIZE_LOG2]);
    assign push_req = take && in_win;

    // The synchronizer's reset value is not a real bus sample, so arming waits
    // until s2 holds live data; a write spanning reset release is never taken.
    always_comb begin
        arm_d = arm_q;
        if (take) begin
            arm_d = 1'b0;
        end else if (live_q[1] && stb_s2_q[STB_WR]) begin
            arm_d = 1'b1;
        end
    end

    assign push_entry.addr = {{TAG_W{1'b0}}, a_q[WIN_SIZE_LOG2-1:0]};
    assign push_entry.data = d_q;

    snoop_fifo #(
        .WIDTH ($bits(fb_wr_t)),
        .AW    (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push_req),
        .data_i   (push_entry),
        .pop_i    (fb_wr_ready),
        .data_o   (head),
        .valid_o  (fb_wr_valid),
        .accept_o (push_ok)
    );

    assign fb_wr_addr      = fb_wr_valid ? head.addr[WIN_SIZE_LOG2-1:0] : '0;
    assign fb_wr_data      = fb_wr_valid ? head.data : 8'h00;
    assign unused_head_tag = |head.addr[15:WIN_SIZE_LOG2];
    assign overflow        = overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A new push always restarts the hold-off, whatever state we are in.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        refresh = 1'b0;
        if (push_ok) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (!busy && !fb_wr_valid) begin
                        refresh = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_write_snoop.sv
// Directed bench for z80_write_snoop: vector table for window decoding plus
// hand sequences for latency, overflow, hold-off, busy and reset corners.
module tb_z80_write_snoop;

    localparam int H = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        MREQ_n, IORQ_n, WR_n, RFSH_n;
    logic [15:0] A;
    logic [7:0]  D;
    logic        fb_wr_valid;
    logic        fb_wr_ready;
    logic [9:0]  fb_wr_addr;
    logic [7:0]  fb_wr_data;
    logic        busy;
    logic        refresh;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int refresh_cnt = 0;
    int refresh_cyc = 0;
    int push_cyc    = 0;
    logic valid_prev = 1'b0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        bit          iorq;
        bit          exp_push;
        logic [9:0]  exp_off;
    } vec_t;

    vec_t vecs [5];

    z80_write_snoop #(
        .WIN_BASE        (16'hE000),
        .WIN_SIZE_LOG2   (10),
        .FIFO_DEPTH_LOG2 (3),
        .HOLDOFF_CYCLES  (H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MREQ_n      (MREQ_n),
        .IORQ_n      (IORQ_n),
        .WR_n        (WR_n),
        .RFSH_n      (RFSH_n),
        .A           (A),
        .D           (D),
        .fb_wr_valid (fb_wr_valid),
        .fb_wr_ready (fb_wr_ready),
        .fb_wr_addr  (fb_wr_addr),
        .fb_wr_data  (fb_wr_data),
        .busy        (busy),
        .refresh     (refresh),
        .overflow    (overflow)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle of each push (rising valid, used with ready=1) and of each refresh pulse.
    always @(negedge clk) begin
        if (fb_wr_valid && !valid_prev) push_cyc = cyc;
        valid_prev = fb_wr_valid;
        if (refresh) begin
            refresh_cnt = refresh_cnt + 1;
            refresh_cyc = cyc;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic z80_write(input logic [15:0] addr, input logic [7:0] data,
                             input bit iorq, input int low);
        $display("z80 write A=%h D=%h iorq=%0d low=%0d cyc=%0d", addr, data, iorq, low, cyc);
        @(negedge clk);
        A = addr;
        D = data;
        MREQ_n = iorq ? 1'b1 : 1'b0;
        IORQ_n = iorq ? 1'b0 : 1'b1;
        @(negedge clk);
        WR_n = 1'b0;
        repeat (low) @(negedge clk);
        WR_n = 1'b1;
        @(negedge clk);
        MREQ_n = 1'b1;
        IORQ_n = 1'b1;
    endtask

    task automatic wait_refresh(input int base, input string name);
        int n;
        n = 0;
        while (refresh_cnt == base && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, refresh_cnt, base + 1);
    endtask

    initial begin
        int rc;
        int p1;

        vecs[0] = '{16'hDFFF, 8'h11, 1'b0, 1'b0, 10'h000};
        vecs[1] = '{16'hE400, 8'h22, 1'b0, 1'b0, 10'h000};
        vecs[2] = '{16'hE010, 8'h33, 1'b1, 1'b0, 10'h000};
        vecs[3] = '{16'hE3FF, 8'h44, 1'b0, 1'b1, 10'h3FF};
        vecs[4] = '{16'hE000, 8'h55, 1'b0, 1'b1, 10'h000};

        rst = 1'b1;
        MREQ_n = 1'b1; IORQ_n = 1'b1; WR_n = 1'b1; RFSH_n = 1'b1;
        A = 16'h0000; D = 8'h00;
        fb_wr_ready = 1'b0;
        busy = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_valid", fb_wr_valid, 0);
        chk("rst_refresh", refresh, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_addr", fb_wr_addr, 0);
        chk("rst_data", fb_wr_data, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Latency: WR_n low seen by s1 at edge 0, valid after edge 3.
        A = 16'hE005; D = 8'hA5; MREQ_n = 1'b0;
        @(negedge clk);
        WR_n = 1'b0;
        @(negedge clk);
        chk("lat_e0_valid", fb_wr_valid, 0);
        @(negedge clk);
        @(negedge clk);
        chk("lat_e2_valid", fb_wr_valid, 0);
        @(negedge clk);
        chk("lat_e3_valid", fb_wr_valid, 1);
        chk("lat_e3_addr", fb_wr_addr, 10'h005);
        chk("lat_e3_data", fb_wr_data, 8'hA5);
        repeat (8) @(negedge clk);
        WR_n = 1'b1;
        @(negedge clk);
        MREQ_n = 1'b1;
        fb_wr_ready = 1'b1;
        @(negedge clk);
        fb_wr_ready = 1'b0;
        chk("lat_single_entry", fb_wr_valid, 0);
        wait_refresh(0, "lat_refresh");
        repeat (10) @(negedge clk);

        // Window decoding table.
        rc = refresh_cnt;
        for (int i = 0; i < 5; i++) begin
            z80_write(vecs[i].addr, vecs[i].data, vecs[i].iorq, 3);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), fb_wr_valid, vecs[i].exp_push);
            if (vecs[i].exp_push) begin
                chk($sformatf("vec%0d_addr", i), fb_wr_addr, vecs[i].exp_off);
                chk($sformatf("vec%0d_data", i), fb_wr_data, vecs[i].data);
                fb_wr_ready = 1'b1;
                @(negedge clk);
                fb_wr_ready = 1'b0;
            end
            if (i == 2) begin
                repeat (30) @(negedge clk);
                chk("outwin_no_refresh", refresh_cnt, rc);
            end
        end
        repeat (40) @(negedge clk);

        // Overflow: 9 writes into a depth-8 FIFO with no consumer.
        for (int i = 0; i < 9; i++) begin
            z80_write(16'hE100 + 16'(i), 8'hC0 + 8'(i), 1'b0, 3);
            @(negedge clk);
            if (i == 7) chk("ovf_after8", overflow, 0);
            if (i == 8) chk("ovf_after9", overflow, 1);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_valid", k), fb_wr_valid, 1);
            chk($sformatf("drain%0d_addr", k), fb_wr_addr, 10'h100 + 10'(k));
            chk($sformatf("drain%0d_data", k), fb_wr_data, 8'hC0 + 8'(k));
            fb_wr_ready = 1'b1;
        end
        @(negedge clk);
        chk("drain_empty", fb_wr_valid, 0);
        chk("ovf_sticky", overflow, 1);
        repeat (40) @(negedge clk);

        // Hold-off timing with ready=1, busy=0.
        rc = refresh_cnt;
        z80_write(16'hE050, 8'h01, 1'b0, 4);
        repeat (40) @(negedge clk);
        chk("rf_once", refresh_cnt, rc + 1);
        chk("rf_delay", refresh_cyc - push_cyc, H + 1);

        // A second write at HOLD cycle 10 restarts the count.
        rc = refresh_cnt;
        z80_write(16'hE051, 8'h02, 1'b0, 4);
        p1 = push_cyc;
        repeat (3) @(negedge clk);
        z80_write(16'hE052, 8'h03, 1'b0, 4);
        chk("restart_gap", push_cyc - p1, 10);
        repeat (40) @(negedge clk);
        chk("restart_once", refresh_cnt, rc + 1);
        chk("restart_delay", refresh_cyc - push_cyc, H + 1);

        // busy held through expiry, released well after.
        rc = refresh_cnt;
        busy = 1'b1;
        z80_write(16'hE060, 8'h04, 1'b0, 4);
        repeat (50) @(negedge clk);
        chk("busy_withheld", refresh_cnt, rc);
        @(posedge clk);
        #1 busy = 1'b0;
        @(negedge clk);
        chk("busy_release_pulse", refresh, 1);
        repeat (30) @(negedge clk);
        chk("busy_once", refresh_cnt, rc + 1);

        // Reset during an ongoing write with queued entries.
        fb_wr_ready = 1'b0;
        z80_write(16'hE070, 8'hA1, 1'b0, 3);
        z80_write(16'hE071, 8'hA2, 1'b0, 3);
        @(negedge clk);
        chk("pre_rst_valid", fb_wr_valid, 1);
        A = 16'hE020; D = 8'h77; MREQ_n = 1'b0;
        @(negedge clk);
        WR_n = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_valid", fb_wr_valid, 0);
        chk("rst_mid_overflow", overflow, 0);
        rst = 1'b0;
        rc = refresh_cnt;
        repeat (8) @(negedge clk);
        chk("rst_ongoing_not_taken", fb_wr_valid, 0);
        WR_n = 1'b1;
        @(negedge clk);
        MREQ_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_refresh_dropped", refresh_cnt, rc);
        z80_write(16'hE030, 8'h88, 1'b0, 3);
        @(negedge clk);
        chk("post_rst_valid", fb_wr_valid, 1);
        chk("post_rst_addr", fb_wr_addr, 10'h030);
        chk("post_rst_data", fb_wr_data, 8'h88);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
